// File: rtl/is_pkg.sv
// Shared IS-tile definitions: L1.5 transducer request/response encodings and
// the PTW responder state type.
package is_pkg;

   localparam logic [4:0] L15_RQTYPE_LOAD      = 5'b00000;
   localparam logic [4:0] L15_RQTYPE_STORE     = 5'b00001;
   localparam logic [4:0] L15_RQTYPE_INTERRUPT = 5'b01001;

   localparam logic [3:0] L15_RESTYPE_LOAD_RET = 4'b0000;
   localparam logic [3:0] L15_RESTYPE_ST_ACK   = 4'b0100;

   localparam logic [2:0] L15_SIZE_8B = 3'b011;

   typedef enum logic [1:0] {
      PTW_IDLE = 2'b00,
      PTW_REQ  = 2'b01,
      PTW_WAIT = 2'b10,
      PTW_RESP = 2'b11
   } ptw_rsp_state_e;

endpackage

// File: rtl/is_bswap64.sv
// Combinational byte reversal of a 64-bit word (little <-> big endian).
module is_bswap64 (
   input  logic [63:0] word,
   output logic [63:0] swapped
);

   always_comb begin
      swapped = '0;
      for (int i = 0; i < 8; i++) begin
         swapped[8*i +: 8] = word[8*(7-i) +: 8];
      end
   end

endmodule

// File: rtl/is_ptw_l15_responder.sv
// Bridges the IOMMU page-table-walker port to the L1.5 transducer, one request
// outstanding; failed or timed-out loads return an all-zero PTE.
module is_ptw_l15_responder
   import is_pkg::*;
#(
   parameter int unsigned PADDR_W        = 40,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter bit          SWAP_ENDIAN    = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               mmu_val_i,
   input  logic               mmu_store_i,
   input  logic               mmu_interrupt_i,
   input  logic [PADDR_W-1:0] mmu_addr_i,
   input  logic [63:0]        mmu_data_i,
   output logic               mmu_ack_o,
   output logic               mmu_rvalid_o,
   output logic [63:0]        mmu_rdata_o,
   output logic               l15_val_o,
   output logic [4:0]         l15_rqtype_o,
   output logic [2:0]         l15_size_o,
   output logic [PADDR_W-1:0] l15_address_o,
   output logic [63:0]        l15_data_o,
   input  logic               l15_ack_i,
   input  logic               l15_resp_val_i,
   input  logic [3:0]         l15_resp_type_i,
   input  logic [63:0]        l15_resp_data0_i,
   input  logic [63:0]        l15_resp_data1_i,
   output logic               l15_resp_ack_o,
   output logic               busy_o,
   output logic               err_o
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   ptw_rsp_state_e      state_q, state_d;
   logic [PADDR_W-1:3]  addr_q;
   logic [63:0]         data_q;
   logic                store_q;
   logic                intr_q;
   logic [63:0]         rdata_q, rdata_d;
   logic                rdata_load;
   logic                err_q, err_set;
   logic [CNT_W-1:0]    cnt_q;
   logic                cnt_clr, cnt_inc;
   logic                latch_req;
   logic                timeout_hit;
   logic [31:0]         cnt_next;
   logic [63:0]         req_swapped, resp_word, resp_swapped, req_data, resp_data;
   logic [4:0]          rqtype;
   logic                unused_addr_lsbs;

   // Request fields are dword-aligned, so the low address bits are dropped.
   assign unused_addr_lsbs = ^mmu_addr_i[2:0];

   is_bswap64 u_req_swap  (.word(data_q),    .swapped(req_swapped));
   is_bswap64 u_resp_swap (.word(resp_word), .swapped(resp_swapped));

   assign resp_word = addr_q[3] ? l15_resp_data1_i : l15_resp_data0_i;
   assign req_data  = SWAP_ENDIAN ? req_swapped  : data_q;
   assign resp_data = SWAP_ENDIAN ? resp_swapped : resp_word;
   assign rqtype    = intr_q ? L15_RQTYPE_INTERRUPT :
                      (store_q ? L15_RQTYPE_STORE : L15_RQTYPE_LOAD);

   // Fires on the wait cycle in which the counter would reach TIMEOUT_CYCLES-1.
   assign cnt_next    = 32'(cnt_q) + 32'd1;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next >= TIMEOUT_CYCLES - 1);

   always_comb begin
      state_d        = state_q;
      mmu_ack_o      = 1'b0;
      mmu_rvalid_o   = 1'b0;
      l15_val_o      = 1'b0;
      l15_resp_ack_o = 1'b0;
      err_set        = 1'b0;
      rdata_load     = 1'b0;
      rdata_d        = rdata_q;
      cnt_clr        = 1'b0;
      cnt_inc        = 1'b0;
      latch_req      = 1'b0;
      case (state_q)
         PTW_IDLE: begin
            // A response here is a leftover from a timeout or reset: drop it.
            l15_resp_ack_o = l15_resp_val_i;
            err_set        = l15_resp_val_i;
            if (mmu_val_i) begin
               latch_req = 1'b1;
               state_d   = PTW_REQ;
            end
         end
         PTW_REQ: begin
            l15_val_o = 1'b1;
            if (l15_ack_i) begin
               mmu_ack_o = 1'b1;
               cnt_clr   = 1'b1;
               state_d   = intr_q ? PTW_IDLE : PTW_WAIT;
            end
         end
         PTW_WAIT: begin
            l15_resp_ack_o = l15_resp_val_i;
            if (l15_resp_val_i) begin
               if (!store_q) begin
                  rdata_load = 1'b1;
                  err_set    = (l15_resp_type_i != L15_RESTYPE_LOAD_RET);
                  rdata_d    = err_set ? 64'd0 : resp_data;
                  state_d    = PTW_RESP;
               end else begin
                  err_set = (l15_resp_type_i != L15_RESTYPE_ST_ACK);
                  state_d = PTW_IDLE;
               end
            end else if (timeout_hit) begin
               err_set = 1'b1;
               if (!store_q) begin
                  rdata_load = 1'b1;
                  rdata_d    = 64'd0;
                  state_d    = PTW_RESP;
               end else begin
                  state_d = PTW_IDLE;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         PTW_RESP: begin
            mmu_rvalid_o = 1'b1;
            state_d      = PTW_IDLE;
         end
         default: state_d = PTW_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PTW_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         store_q <= 1'b0;
         intr_q  <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (latch_req) begin
            addr_q  <= mmu_addr_i[PADDR_W-1:3];
            data_q  <= mmu_data_i;
            store_q <= mmu_store_i;
            intr_q  <= mmu_interrupt_i;
         end
         if (rdata_load) rdata_q <= rdata_d;
         if (err_set)    err_q   <= 1'b1;
         if (cnt_clr) begin
            cnt_q <= '0;
         end else if (cnt_inc && (TIMEOUT_CYCLES != 0) && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign mmu_rdata_o   = rdata_q;
   assign l15_rqtype_o  = l15_val_o ? rqtype : 5'd0;
   assign l15_size_o    = l15_val_o ? L15_SIZE_8B : 3'd0;
   assign l15_address_o = l15_val_o ? {addr_q, 3'b000} : '0;
   assign l15_data_o    = l15_val_o ? req_data : 64'd0;
   assign busy_o        = (state_q != PTW_IDLE);
   assign err_o         = err_q;

endmodule
